mips_cycle_sequencer: RTL

//  Multi-cycle control FSM for the single-issue MIPS datapath. Sequences each instruction

---
 rtl/mips_cycle_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer: multi-cycle control FSM for the MIPS datapath.
// Define SINGLE_STEP_EN to add the step input and the PAUSE state.
module mips_cycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       alu_busy,
    input  logic       alu_zero,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic       ctl_mem_read,
    input  logic       ctl_mem_write,
    input  logic       ctl_reg_write,
    input  logic       ctl_branch,
    input  logic       ctl_jump,
    output logic       imem_ren,
    output logic       decode_en,
    output logic       alu_en,
    output logic       dmem_ren,
    output logic       dmem_wen,
    output logic       rf_wen,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       busy,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_DEC1  = 4'd2,
        S_DEC2  = 4'd3,
        S_EXEC  = 4'd4,
        S_MEM   = 4'd5,
        S_WB    = 4'd6,
        S_PCUPD = 4'd7,
        S_HALT  = 4'd8,
        S_PAUSE = 4'd9
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_t          st;
    state_t          nxt;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_inc;
    logic [TO_W-1:0] cnt_nxt;
    logic            err_nxt;
    logic [1:0]      src_nxt;

    assign cnt_inc = cnt + TO_W'(1);
    assign state   = st;

    // Counter only runs while parked on a handshake; any move clears it.
    always_comb begin
        nxt     = st;
        cnt_nxt = '0;
        err_nxt = error;
        unique case (st)
            S_IDLE: begin
                if (start)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    nxt = S_DEC1;
                end else if (cnt_inc == TO_LIM) begin
                    nxt     = S_HALT;
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_DEC1: nxt = S_DEC2;
            S_DEC2: nxt = S_EXEC;
            S_EXEC: begin
                if (!alu_busy) begin
                    if (ctl_mem_read || ctl_mem_write)
                        nxt = S_MEM;
                    else if (ctl_reg_write)
                        nxt = S_WB;
                    else
                        nxt = S_PCUPD;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    nxt = ctl_reg_write ? S_WB : S_PCUPD;
                end else if (cnt_inc == TO_LIM) begin
                    nxt     = S_HALT;
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WB: nxt = S_PCUPD;
            S_PCUPD: begin
                if (halt_req)
                    nxt = S_HALT;
                else
`ifdef SINGLE_STEP_EN
                    nxt = S_PAUSE;
`else
                    nxt = S_FETCH;
`endif
            end
            S_HALT: begin
                if (start) begin
                    nxt     = S_FETCH;
                    err_nxt = 1'b0;
                end
            end
            S_PAUSE: begin
`ifdef SINGLE_STEP_EN
                if (halt_req)
                    nxt = S_HALT;
                else if (step)
                    nxt = S_FETCH;
`else
                nxt = S_FETCH;
`endif
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src_nxt = 2'b00;
        if (nxt == S_PCUPD) begin
            if (ctl_jump)
                src_nxt = 2'b10;
            else if (ctl_branch && alu_zero)
                src_nxt = 2'b01;
        end
    end

    // Outputs are registered from the next state so they track st exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            cnt       <= '0;
            error     <= 1'b0;
            imem_ren  <= 1'b0;
            decode_en <= 1'b0;
            alu_en    <= 1'b0;
            dmem_ren  <= 1'b0;
            dmem_wen  <= 1'b0;
            rf_wen    <= 1'b0;
            pc_en     <= 1'b0;
            pc_src    <= 2'b00;
            busy      <= 1'b0;
        end else begin
            st        <= nxt;
            cnt       <= cnt_nxt;
            error     <= err_nxt;
            imem_ren  <= (nxt == S_FETCH);
            decode_en <= (nxt == S_DEC1) || (nxt == S_DEC2);
            alu_en    <= (nxt == S_EXEC);
            dmem_ren  <= (nxt == S_MEM) && ctl_mem_read;
            dmem_wen  <= (nxt == S_MEM) && ctl_mem_write;
            rf_wen    <= (nxt == S_WB);
            pc_en     <= (nxt == S_PCUPD);
            pc_src    <= src_nxt;
            busy      <= (nxt != S_IDLE) && (nxt != S_HALT);
        end
    end

endmodule
